// File: rtl/cam_match_resolver_if.sv
// Search/result handshake bundle between the CAM array, the match resolver and lookup logic.
// The resolver uses the slave modport; the CAM side and lookup consumer use master.
interface cam_match_resolver_if #(
  parameter int CAM_DEPTH  = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  search_valid;
  logic                  search_ready;
  logic [CAM_DEPTH-1:0]  decoded_match_address;
  logic                  result_valid;
  logic                  result_ready;
  logic [ADDR_WIDTH-1:0] match_address;
  logic                  match_last;
  logic                  no_match;
  logic [ADDR_WIDTH:0]   match_count;

  modport master (
    output search_valid, decoded_match_address, result_ready,
    input  search_ready, result_valid, match_address, match_last, no_match, match_count
  );

  modport slave (
    input  search_valid, decoded_match_address, result_ready,
    output search_ready, result_valid, match_address, match_last, no_match, match_count
  );
endinterface

// File: rtl/cam_match_resolver.sv
// Serialises one multi-hot CAM match vector into encoded row addresses, one per handshake.
// Define CAM_MATCH_HIGH_FIRST_EN to emit hits highest row first instead of lowest first.
module cam_match_resolver #(
  parameter int CAM_DEPTH  = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  cam_match_resolver_if.slave bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                state_q, state_d;
  logic [CAM_DEPTH-1:0]  pending_q, pending_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  last_q, last_d;
  logic                  nomatch_q, nomatch_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [CAM_DEPTH-1:0]  remaining;

  function automatic logic [ADDR_WIDTH:0] popcount(input logic [CAM_DEPTH-1:0] v);
    popcount = '0;
    for (int i = 0; i < CAM_DEPTH; i++) popcount = popcount + (ADDR_WIDTH+1)'(v[i]);
  endfunction

  // The scan direction is set by loop order: the final assignment wins priority.
  function automatic logic [ADDR_WIDTH-1:0] first_hit(input logic [CAM_DEPTH-1:0] v);
    first_hit = '0;
`ifdef CAM_MATCH_HIGH_FIRST_EN
    for (int i = 0; i < CAM_DEPTH; i++)
      if (v[i]) first_hit = i[ADDR_WIDTH-1:0];
`else
    for (int i = CAM_DEPTH-1; i >= 0; i--)
      if (v[i]) first_hit = i[ADDR_WIDTH-1:0];
`endif
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d   = state_q;
    pending_d = pending_q;
    valid_d   = valid_q;
    addr_d    = addr_q;
    last_d    = last_q;
    nomatch_d = nomatch_q;
    count_d   = count_q;
    remaining = pending_q & ~(CAM_DEPTH'(1) << addr_q);

    unique case (state_q)
      IDLE: begin
        if (bus.search_valid) begin
          state_d   = SCAN;
          pending_d = bus.decoded_match_address;
          count_d   = popcount(bus.decoded_match_address);
          valid_d   = 1'b1;
          if (bus.decoded_match_address == '0) begin
            nomatch_d = 1'b1;
            last_d    = 1'b1;
            addr_d    = '0;
          end else begin
            nomatch_d = 1'b0;
            addr_d    = first_hit(bus.decoded_match_address);
            last_d    = (popcount(bus.decoded_match_address) == (ADDR_WIDTH+1)'(1));
          end
        end
      end
      SCAN: begin
        if (valid_q && bus.result_ready) begin
          if (last_q) begin
            state_d   = IDLE;
            pending_d = '0;
            valid_d   = 1'b0;
            addr_d    = '0;
            last_d    = 1'b0;
            nomatch_d = 1'b0;
            count_d   = '0;
          end else begin
            pending_d = remaining;
            addr_d    = first_hit(remaining);
            last_d    = (popcount(remaining) == (ADDR_WIDTH+1)'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      last_q    <= 1'b0;
      nomatch_q <= 1'b0;
      count_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      state_q   <= state_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      last_q    <= last_d;
      nomatch_q <= nomatch_d;
      count_q   <= count_d;
    end
  end

  assign bus.search_ready  = (state_q == IDLE);
  assign bus.result_valid  = valid_q;
  assign bus.match_address = addr_q;
  assign bus.match_last    = last_q;
  assign bus.no_match      = nomatch_q;
  assign bus.match_count   = count_q;

endmodule

// File: tb/tb_cam_match_resolver.sv
// Directed bench for cam_match_resolver: table of whole searches plus hand-written
// back-pressure, ignored-search and mid-search reset sequences.
module tb_cam_match_resolver;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cam_match_resolver_if #(.CAM_DEPTH(8), .ADDR_WIDTH(3)) bus ();

  cam_match_resolver #(.CAM_DEPTH(8), .ADDR_WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // seq holds the expected address order, one hex digit per result, first result in bits 3:0.
  typedef struct packed {
    logic [7:0]  vec;
    logic [3:0]  count;
    logic [3:0]  n_res;
    logic [31:0] seq;
    logic        nm;
  } search_t;

  search_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_search(input search_t s);
    logic [3:0] exp_addr;
    bus.search_valid          = 1'b1;
    bus.decoded_match_address = s.vec;
    tick();
    bus.search_valid = 1'b0;
    for (int k = 0; k < int'(s.n_res); k++) begin
      exp_addr = s.seq[4*k +: 4];
      check($sformatf("v%02h r%0d valid", s.vec, k), 32'(bus.result_valid), 32'd1);
      check($sformatf("v%02h r%0d addr", s.vec, k), 32'(bus.match_address), 32'(exp_addr));
      check($sformatf("v%02h r%0d last", s.vec, k), 32'(bus.match_last),
            32'(k == int'(s.n_res) - 1));
      check($sformatf("v%02h r%0d no_match", s.vec, k), 32'(bus.no_match), 32'(s.nm));
      check($sformatf("v%02h r%0d count", s.vec, k), 32'(bus.match_count), 32'(s.count));
      check($sformatf("v%02h r%0d sready", s.vec, k), 32'(bus.search_ready), 32'd0);
      tick();
    end
    check($sformatf("v%02h end valid", s.vec), 32'(bus.result_valid), 32'd0);
    check($sformatf("v%02h end sready", s.vec), 32'(bus.search_ready), 32'd1);
    check($sformatf("v%02h end count", s.vec), 32'(bus.match_count), 32'd0);
  endtask

  initial begin
    bus.search_valid          = 1'b0;
    bus.decoded_match_address = 8'h00;
    bus.result_ready          = 1'b1;

`ifdef CAM_MATCH_HIGH_FIRST_EN
    tbl[0] = '{vec: 8'b0010_0100, count: 4'd2, n_res: 4'd2, seq: 32'h25,        nm: 1'b0};
    tbl[4] = '{vec: 8'b1000_0001, count: 4'd2, n_res: 4'd2, seq: 32'h07,        nm: 1'b0};
    tbl[5] = '{vec: 8'hFF,        count: 4'd8, n_res: 4'd8, seq: 32'h0123_4567, nm: 1'b0};
    tbl[6] = '{vec: 8'b0101_1010, count: 4'd4, n_res: 4'd4, seq: 32'h1346,      nm: 1'b0};
`else
    tbl[0] = '{vec: 8'b0010_0100, count: 4'd2, n_res: 4'd2, seq: 32'h52,        nm: 1'b0};
    tbl[4] = '{vec: 8'b1000_0001, count: 4'd2, n_res: 4'd2, seq: 32'h70,        nm: 1'b0};
    tbl[5] = '{vec: 8'hFF,        count: 4'd8, n_res: 4'd8, seq: 32'h7654_3210, nm: 1'b0};
    tbl[6] = '{vec: 8'b0101_1010, count: 4'd4, n_res: 4'd4, seq: 32'h6431,      nm: 1'b0};
`endif
    tbl[1] = '{vec: 8'h00, count: 4'd0, n_res: 4'd1, seq: 32'h0, nm: 1'b1};
    tbl[2] = '{vec: 8'h01, count: 4'd1, n_res: 4'd1, seq: 32'h0, nm: 1'b0};
    tbl[3] = '{vec: 8'h80, count: 4'd1, n_res: 4'd1, seq: 32'h7, nm: 1'b0};

    // Reset state while rst is held low.
    #2;
    check("reset sready", 32'(bus.search_ready), 32'd1);
    check("reset valid", 32'(bus.result_valid), 32'd0);
    check("reset addr", 32'(bus.match_address), 32'd0);
    check("reset last", 32'(bus.match_last), 32'd0);
    check("reset no_match", 32'(bus.no_match), 32'd0);
    check("reset count", 32'(bus.match_count), 32'd0);
    #10 rst = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_search(tbl[i]);

    // Back-pressure: the first hit must stay put while result_ready is low.
    bus.result_ready          = 1'b0;
    bus.search_valid          = 1'b1;
    bus.decoded_match_address = 8'b1000_0001;
    tick();
    bus.search_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall %0d valid", k), 32'(bus.result_valid), 32'd1);
      check($sformatf("stall %0d addr", k), 32'(bus.match_address), 32'(tbl[4].seq[3:0]));
      check($sformatf("stall %0d last", k), 32'(bus.match_last), 32'd0);
      tick();
    end
    bus.result_ready = 1'b1;
    check("stall rel addr0", 32'(bus.match_address), 32'(tbl[4].seq[3:0]));
    tick();
    check("stall rel addr1", 32'(bus.match_address), 32'(tbl[4].seq[7:4]));
    check("stall rel last1", 32'(bus.match_last), 32'd1);
    tick();
    check("stall end valid", 32'(bus.result_valid), 32'd0);

    // search_valid pulses during SCAN with a different vector must be ignored.
    bus.search_valid          = 1'b1;
    bus.decoded_match_address = 8'hFF;
    tick();
    bus.decoded_match_address = 8'h0F;
    for (int k = 0; k < 8; k++) begin
      bus.search_valid = (k >= 1 && k <= 5);
      check($sformatf("ign r%0d addr", k), 32'(bus.match_address), 32'(tbl[5].seq[4*k +: 4]));
      check($sformatf("ign r%0d count", k), 32'(bus.match_count), 32'd8);
      tick();
    end
    check("ign end valid", 32'(bus.result_valid), 32'd0);
    check("ign end sready", 32'(bus.search_ready), 32'd1);
    tick();
    check("ign idle valid", 32'(bus.result_valid), 32'd0);

    // Asynchronous reset in the middle of a search discards it.
    bus.search_valid          = 1'b1;
    bus.decoded_match_address = 8'b0001_1010;
    tick();
    bus.search_valid = 1'b0;
`ifdef CAM_MATCH_HIGH_FIRST_EN
    check("rst first addr", 32'(bus.match_address), 32'd4);
`else
    check("rst first addr", 32'(bus.match_address), 32'd1);
`endif
    tick();
    check("rst second addr", 32'(bus.match_address), 32'd3);
    #2 rst = 1'b0;
    #1;
    check("async sready", 32'(bus.search_ready), 32'd1);
    check("async valid", 32'(bus.result_valid), 32'd0);
    check("async addr", 32'(bus.match_address), 32'd0);
    check("async last", 32'(bus.match_last), 32'd0);
    check("async no_match", 32'(bus.no_match), 32'd0);
    check("async count", 32'(bus.match_count), 32'd0);
    #3 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("post rst %0d valid", k), 32'(bus.result_valid), 32'd0);
      check($sformatf("post rst %0d sready", k), 32'(bus.search_ready), 32'd1);
    end

    run_search(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
